// File: rtl/mult_8x8_seq_ctrl.sv
// Sequenced 8x8 multiply over one shared external 4x4 approximate multiplier, one quadrant per cycle.
// Optional ZERO_SKIP_EN: quadrants with a zero A or B nibble are skipped at acceptance.
module mult_8x8_seq_ctrl #(
  parameter logic [3:0] QMODE = 4'b0011,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_r,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  output logic             mul_sel,
  input  logic [7:0]       mul_r,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state_reg;
  logic [7:0]  a_reg;
  logic [7:0]  b_reg;
  logic [3:0]  pend_reg;
  logic [15:0] acc_reg;

  logic [3:0]  quad_active;
  logic [3:0]  pend_next;
  logic [1:0]  step;
  logic [15:0] prod_ext;
  logic [15:0] addend;
  logic [15:0] acc_next;

  // Quadrant q pairs A nibble q[1] with B nibble q[0].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_quad
`ifdef ZERO_SKIP_EN
      assign quad_active[gi] = (in_a[(gi / 2) * 4 +: 4] != 4'd0) &&
                               (in_b[(gi % 2) * 4 +: 4] != 4'd0);
`else
      assign quad_active[gi] = 1'b1;
`endif
    end
  endgenerate

  // Current step is the lowest quadrant still pending.
  always_comb begin
    step = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_reg[i]) step = 2'(i);
    end
  end

  always_comb begin
    mul_a   = 4'd0;
    mul_b   = 4'd0;
    mul_sel = 1'b0;
    if (state_reg == MUL) begin
      mul_a   = step[1] ? a_reg[7:4] : a_reg[3:0];
      mul_b   = step[0] ? b_reg[7:4] : b_reg[3:0];
      mul_sel = QMODE[step];
    end
  end

  always_comb begin
    prod_ext = {8'd0, mul_r};
    case (step)
      2'd0:    addend = prod_ext;
      2'd3:    addend = prod_ext << 8;
      default: addend = prod_ext << 4;
    endcase
    acc_next  = acc_reg + addend;
    pend_next = pend_reg & ~(4'b0001 << step);
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= 8'd0;
      b_reg     <= 8'd0;
      pend_reg  <= 4'd0;
      acc_reg   <= 16'd0;
      out_r     <= 16'd0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            acc_reg <= 16'd0;
            if (quad_active == 4'd0) begin
              out_r     <= 16'd0;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end else begin
              pend_reg  <= quad_active;
              state_reg <= MUL;
            end
          end
        end
        MUL: begin
          acc_reg  <= acc_next;
          pend_reg <= pend_next;
          if (pend_next == 4'd0) begin
            out_r     <= acc_next;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Self-checking bench for mult_8x8_seq_ctrl: exact 4x4 multiplier model, arithmetic product reference.
module tb_mult_8x8_seq_ctrl;

  localparam logic [3:0] QMODE = 4'b0011;
  localparam int         CNT_W = 16;
  localparam int         TMO   = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_r;
  logic [3:0]       mul_a;
  logic [3:0]       mul_b;
  logic             mul_sel;
  logic [7:0]       mul_r;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  logic             force_ff;
  int               total;
  int               bad;
  logic [CNT_W-1:0] exp_count;

  always #5 clk = ~clk;

  // Shared multiplier: exact product, or stuck at 8'hFF for the wrap scenario.
  assign mul_r = force_ff ? 8'hFF : 8'({4'd0, mul_a} * {4'd0, mul_b});

  mult_8x8_seq_ctrl #(.QMODE(QMODE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .mul_a(mul_a), .mul_b(mul_b), .mul_sel(mul_sel), .mul_r(mul_r),
    .busy(busy), .op_count(op_count)
  );

  // Number of MUL cycles the controller should spend on an operand pair.
  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef ZERO_SKIP_EN
    int n;
    n = 0;
    for (int q = 0; q < 4; q++) begin
      if (((q >= 2 ? a[7:4] : a[3:0]) != 4'd0) && ((q % 2 == 1 ? b[7:4] : b[3:0]) != 4'd0)) n++;
    end
    return n;
`else
    return 4;
`endif
  endfunction

  // One operation: offer operands, wait for result, hold off out_ready for 'hold' cycles, handshake.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                       output logic [15:0] r, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    r = out_r;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (lat < TMO) exp_count++;
    $display("op a=%02h b=%02h r=%04h lat=%0d", a, b, r, lat);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = 8'd0; in_b = 8'd0; force_ff = 1'b0;
    repeat (3) @(negedge clk);
    exp_count = '0;
    total++;
    if ({out_valid, busy, out_r, op_count, mul_a, mul_b, mul_sel} !== '0) begin
      bad++;
      $display("FAIL reset_state: out_valid=%b busy=%b out_r=%h op_count=%0d mul=%h/%h/%b required all zero",
               out_valid, busy, out_r, op_count, mul_a, mul_b, mul_sel);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_full_ff;
    logic [15:0] r;
    int lat;
    do_op(8'hFF, 8'hFF, 0, r, lat);
    total++;
    if (r !== 16'hFE01) begin bad++; $display("FAIL ff_result: got %h required fe01", r); end
    total++;
    if (lat !== exp_lat(8'hFF, 8'hFF)) begin bad++; $display("FAIL ff_latency: got %0d required %0d", lat, exp_lat(8'hFF, 8'hFF)); end
    total++;
    if (op_count !== exp_count) begin bad++; $display("FAIL ff_op_count: got %0d required %0d", op_count, exp_count); end
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL ff_ready_after: in_ready=%b busy=%b required 1/0", in_ready, busy); end
  endtask

  task automatic test_sequence;
    logic [7:0] a, b;
    logic [8:0] got, want;
    a = 8'h12; b = 8'h34;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      got  = {mul_a, mul_b, mul_sel};
      want = {(s >= 2 ? a[7:4] : a[3:0]), (s % 2 == 1 ? b[7:4] : b[3:0]), QMODE[s]};
      total++;
      if (got !== want || busy !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL seq_step%0d: mul_a/b/sel=%h/%h/%b busy=%b out_valid=%b required %h/%h/%b busy=1 out_valid=0",
                 s, mul_a, mul_b, mul_sel, busy, out_valid, want[8:5], want[4:1], want[0]);
      end
      @(negedge clk);
    end
    total++;
    if (out_valid !== 1'b1 || out_r !== 16'h03A8 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL seq_result: out_valid=%b out_r=%h in_ready=%b required 1/03a8/0", out_valid, out_r, in_ready);
    end
    total++;
    if ({mul_a, mul_b, mul_sel} !== 9'd0) begin
      bad++;
      $display("FAIL seq_mul_idle: got %h/%h/%b required 0/0/0", mul_a, mul_b, mul_sel);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count++;
    $display("op a=%02h b=%02h r=03a8 sequence", a, b);
    total++;
    if (op_count !== exp_count) begin bad++; $display("FAIL seq_op_count: got %0d required %0d", op_count, exp_count); end
  endtask

  task automatic test_quad_skip;
    logic [15:0] r;
    int lat;
    do_op(8'h05, 8'h30, 0, r, lat);
    total++;
    if (r !== 16'h00F0) begin bad++; $display("FAIL skip_result: got %h required 00f0", r); end
    total++;
    if (lat !== exp_lat(8'h05, 8'h30)) begin bad++; $display("FAIL skip_latency: got %0d required %0d", lat, exp_lat(8'h05, 8'h30)); end
  endtask

  task automatic test_backpressure;
    logic [7:0] a, b;
    logic [15:0] r0;
    int lat;
    int stray;
    a = 8'($urandom); b = 8'($urandom);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < TMO) begin @(negedge clk); lat++; end
    r0 = out_r;
    total++;
    if (r0 !== 16'(16'(a) * 16'(b)) || lat >= TMO) begin
      bad++;
      $display("FAIL bp_result: got %h required %h (wait %0d)", r0, 16'(16'(a) * 16'(b)), lat);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_r !== r0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: out_valid=%b out_r=%h in_ready=%b required 1/%h/0", k, out_valid, out_r, in_ready, r0);
      end
      in_valid = ~in_valid;
      in_a = 8'($urandom); in_b = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count++;
    $display("op a=%02h b=%02h r=%04h backpressure", a, b, r0);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== exp_count) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b op_count=%0d required 0/1/%0d", out_valid, in_ready, op_count, exp_count);
    end
    stray = 0;
    repeat (6) begin @(negedge clk); if (busy || out_valid) stray++; end
    total++;
    if (stray !== 0) begin bad++; $display("FAIL bp_stray_accept: busy cycles=%0d required 0", stray); end
  endtask

  task automatic test_reset_mid;
    int seen;
    logic [15:0] r;
    int lat;
    @(negedge clk);
    in_a = 8'hA7; in_b = 8'h5C; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = '0;
    total++;
    if (out_valid !== 1'b0 || out_r !== 16'd0 || in_ready !== 1'b1 || op_count !== exp_count) begin
      bad++;
      $display("FAIL midreset_state: out_valid=%b out_r=%h in_ready=%b op_count=%0d required 0/0000/1/0",
               out_valid, out_r, in_ready, op_count);
    end
    seen = 0;
    repeat (8) begin @(negedge clk); if (out_valid) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midreset_no_output: out_valid cycles=%0d required 0", seen); end
    do_op(8'h3B, 8'hC6, 1, r, lat);
    total++;
    if (r !== 16'(16'h3B * 16'hC6)) begin bad++; $display("FAIL midreset_next_op: got %h required %h", r, 16'(16'h3B * 16'hC6)); end
  endtask

  task automatic test_wrap;
    logic [7:0] a, b;
    logic [15:0] r;
    int lat;
    force_ff = 1'b1;
    a = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
    b = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
    do_op(a, b, 0, r, lat);
    force_ff = 1'b0;
    total++;
    if (r !== 16'h1FDF) begin bad++; $display("FAIL wrap_result: got %h required 1fdf", r); end
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic [15:0] r, want;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      if (i % 4 == 1) a[3:0] = 4'd0;
      if (i % 5 == 2) b[7:4] = 4'd0;
      if (i == 7) begin a = 8'd0; b = 8'd0; end
      want = 16'(16'(a) * 16'(b));
      do_op(a, b, int'($urandom_range(0, 3)), r, lat);
      total++;
      if (r !== want || lat !== exp_lat(a, b) || op_count !== exp_count) begin
        bad++;
        $display("FAIL rand%0d: r=%h lat=%0d op_count=%0d required %h/%0d/%0d",
                 i, r, lat, op_count, want, exp_lat(a, b), exp_count);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_count = '0;
    test_reset;
    test_full_ff;
    test_sequence;
    test_quad_skip;
    test_backpressure;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
